// File: rtl/ddr_pkg.sv
// ddr_pkg: command encodings, default DDR timings and refresh sequencer states
package ddr_pkg;
    localparam int T_RP_CK  = 6;
    localparam int T_RFC_CK = 88;
    typedef enum logic [1:0] {
        CMD_NOP  = 2'b00,
        CMD_PREA = 2'b01,
        CMD_REF  = 2'b10,
        CMD_RSVD = 2'b11
    } cmd_op_t;
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_DRAIN    = 3'd1,
        S_PREA     = 3'd2,
        S_WAIT_RP  = 3'd3,
        S_REF      = 3'd4,
        S_WAIT_RFC = 3'd5
    } ref_seq_state_t;
endpackage

// File: rtl/delay_timer.sv
// delay_timer: loadable down-counter that parks at zero and flags it
module delay_timer #(
    parameter int W = 7
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);
    logic [W-1:0] cnt_q, cnt_d;
    // A load wins over counting; the count stops at zero instead of wrapping
    always_comb cnt_d = load_i ? load_val_i : (cnt_q != '0 ? cnt_q - 1'b1 : cnt_q);
    // Counter register
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    assign zero_o = cnt_q == '0;
endmodule

// File: rtl/refresh_cmd_sequencer.sv
// refresh_cmd_sequencer: turns queued refresh grants into PREA/REF command sequences with tRP/tRFC spacing
module refresh_cmd_sequencer
    import ddr_pkg::*;
#(
    parameter int T_RP     = T_RP_CK,
    parameter int T_RFC    = T_RFC_CK,
    parameter int MAX_PEND = 8,
    parameter int PEND_W   = 4
) (
    input  logic              core_clk,
    input  logic              core_arstn,
    input  logic              ref_do,
    output logic              sched_hold,
    input  logic              sched_idle,
    input  logic              any_bank_open,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [1:0]        cmd_op,
    output logic              ref_done,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);
    localparam int TW = $clog2(T_RP > T_RFC ? T_RP : T_RFC);

    ref_seq_state_t    state_q, state_d;
    logic [PEND_W-1:0] pending_q, pending_d;
    logic              overflow_q, overflow_d;
    logic              drain_q, drain_d;
    logic              hs, ref_hs, full, tmr_zero;
    logic [TW-1:0]     ld_val;
    cmd_op_t           op;

    assign cmd_valid  = state_q == S_PREA || state_q == S_REF;
    assign op         = state_q == S_PREA ? CMD_PREA : state_q == S_REF ? CMD_REF : CMD_NOP;
    assign cmd_op     = op;
    assign sched_hold = state_q != S_IDLE;
    assign hs         = cmd_valid && cmd_ready;
    assign ref_hs     = hs && state_q == S_REF;
    assign ref_done   = state_q == S_WAIT_RFC && tmr_zero;
    assign pending    = pending_q;
    assign overflow   = overflow_q;
    assign full       = pending_q == PEND_W'(MAX_PEND);
    // The wait states exit when the timer reads zero, so load two less than the spacing
    assign ld_val     = state_q == S_PREA ? TW'(T_RP - 2) : TW'(T_RFC - 2);

    // Grant queue: count in, count out on REF handshake, drop and flag when full
    always_comb begin
        pending_d  = (ref_do && !ref_hs && !full) ? pending_q + 1'b1 :
                     (ref_hs && !ref_do)          ? pending_q - 1'b1 : pending_q;
        overflow_d = overflow_q || (ref_do && full);
        drain_d    = state_q == S_DRAIN;
    end

    // Sequence control; DRAIN trusts sched_idle only once hold has been visible for a cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (pending_q != '0 || ref_do) state_d = S_DRAIN;
            S_DRAIN:    if (drain_q && sched_idle) state_d = any_bank_open ? S_PREA : S_REF;
            S_PREA:     if (hs) state_d = S_WAIT_RP;
            S_WAIT_RP:  if (tmr_zero) state_d = S_REF;
            S_REF:      if (hs) state_d = S_WAIT_RFC;
            S_WAIT_RFC: if (tmr_zero) state_d = pending_q != '0 ? S_REF : S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // State registers
    always_ff @(posedge core_clk or negedge core_arstn)
        if (!core_arstn) begin
            state_q    <= S_IDLE;
            pending_q  <= '0;
            overflow_q <= 1'b0;
            drain_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            drain_q    <= drain_d;
        end

    delay_timer #(.W(TW)) u_timer (
        .clk_i      (core_clk),
        .rst_ni     (core_arstn),
        .load_i     (hs),
        .load_val_i (ld_val),
        .zero_o     (tmr_zero)
    );
endmodule

// File: tb/tb_refresh_cmd_sequencer.sv
// tb_refresh_cmd_sequencer: scenario tasks plus randomized run against a grant/handshake scoreboard
module tb_refresh_cmd_sequencer;
    localparam int TRP = 6, TRFC = 88, MAXP = 8;
    logic core_clk = 0, core_arstn = 0, ref_do = 0, sched_idle = 0, any_bank_open = 0, cmd_ready = 0;
    logic sched_hold, cmd_valid, ref_done, overflow;
    logic [1:0] cmd_op;
    logic [3:0] pending;
    int errors = 0, checks = 0, cyc = 0;
    int m_pend = 0;
    logic m_ovf = 0;
    int q_ref_hs[$], q_prea_hs[$], q_done[$], q_refv[$];
    int hold_rise, hold_fall, n_rise, n_fall, n_valid;
    logic prev_hold = 0, prev_refv = 0;

    refresh_cmd_sequencer dut (
        .core_clk(core_clk), .core_arstn(core_arstn), .ref_do(ref_do), .sched_hold(sched_hold),
        .sched_idle(sched_idle), .any_bank_open(any_bank_open), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .cmd_op(cmd_op), .ref_done(ref_done), .pending(pending),
        .overflow(overflow)
    );

    always #5 core_clk = ~core_clk;

    task automatic clr_log();
        q_ref_hs.delete(); q_prea_hs.delete(); q_done.delete(); q_refv.delete();
        hold_rise = -1; hold_fall = -1; n_rise = 0; n_fall = 0; n_valid = 0;
    endtask

    // Drive one cycle of inputs, log protocol events of this cycle, update the grant model, advance
    task automatic tick(input logic rd, input logic si, input logic bo, input logic rdy);
        logic ref_ev;
        ref_do = rd; sched_idle = si; any_bank_open = bo; cmd_ready = rdy;
        ref_ev = cmd_valid && rdy && cmd_op == 2'b10;
        if (cmd_valid) n_valid++;
        if (ref_ev) q_ref_hs.push_back(cyc);
        if (cmd_valid && rdy && cmd_op == 2'b01) q_prea_hs.push_back(cyc);
        if (ref_done) q_done.push_back(cyc);
        if (cmd_valid && cmd_op == 2'b10 && !prev_refv) q_refv.push_back(cyc);
        if (sched_hold && !prev_hold) begin hold_rise = cyc; n_rise++; end
        if (!sched_hold && prev_hold) begin hold_fall = cyc; n_fall++; end
        prev_hold = sched_hold;
        prev_refv = cmd_valid && cmd_op == 2'b10;
        if (rd && m_pend == MAXP) m_ovf = 1;
        if (rd && !ref_ev && m_pend < MAXP) m_pend++;
        else if (ref_ev && !rd) m_pend--;
        @(posedge core_clk); #1; cyc++;
    endtask

    task automatic test_reset();
        core_arstn = 0;
        @(posedge core_clk); #1;
        checks++; if (sched_hold !== 1'b0) begin errors++; $display("FAIL reset_hold got=%b exp=0", sched_hold); end
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", cmd_valid); end
        checks++; if (cmd_op !== 2'b00) begin errors++; $display("FAIL reset_op got=%b exp=00", cmd_op); end
        checks++; if (ref_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", ref_done); end
        checks++; if (pending !== 4'd0) begin errors++; $display("FAIL reset_pending got=%0d exp=0", pending); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        @(posedge core_clk); #1;
        core_arstn = 1;
        m_pend = 0; m_ovf = 0; prev_hold = 0; prev_refv = 0;
    endtask

    task automatic test_single_closed();
        int t0;
        clr_log(); t0 = cyc;
        tick(1, 1, 0, 1);
        repeat (99) tick(0, 1, 0, 1);
        checks++; if (hold_rise != t0 + 1) begin errors++; $display("FAIL closed_hold_rise got=%0d exp=%0d", hold_rise, t0 + 1); end
        checks++; if (q_refv.size() != 1 || q_refv[0] != t0 + 3) begin errors++; $display("FAIL closed_ref_offer n=%0d got=%0d exp=%0d", q_refv.size(), q_refv.size() > 0 ? q_refv[0] : -1, t0 + 3); end
        checks++; if (q_prea_hs.size() != 0) begin errors++; $display("FAIL closed_no_prea got=%0d exp=0", q_prea_hs.size()); end
        checks++; if (q_done.size() != 1 || q_done[0] != t0 + 3 + TRFC - 1) begin errors++; $display("FAIL closed_done n=%0d got=%0d exp=%0d", q_done.size(), q_done.size() > 0 ? q_done[0] : -1, t0 + 3 + TRFC - 1); end
        checks++; if (hold_fall != t0 + 3 + TRFC) begin errors++; $display("FAIL closed_hold_fall got=%0d exp=%0d", hold_fall, t0 + 3 + TRFC); end
        checks++; if (pending !== 4'd0) begin errors++; $display("FAIL closed_pending got=%0d exp=0", pending); end
    endtask

    task automatic test_single_open();
        int t0;
        clr_log(); t0 = cyc;
        tick(1, 1, 1, 1);
        repeat (105) tick(0, 1, 1, 1);
        checks++; if (q_prea_hs.size() != 1 || q_prea_hs[0] != t0 + 3) begin errors++; $display("FAIL open_prea n=%0d got=%0d exp=%0d", q_prea_hs.size(), q_prea_hs.size() > 0 ? q_prea_hs[0] : -1, t0 + 3); end
        checks++; if (q_refv.size() != 1 || q_refv[0] != t0 + 3 + TRP) begin errors++; $display("FAIL open_ref_offer n=%0d got=%0d exp=%0d", q_refv.size(), q_refv.size() > 0 ? q_refv[0] : -1, t0 + 3 + TRP); end
        checks++; if (q_done.size() != 1 || q_done[0] != t0 + 3 + TRP + TRFC - 1) begin errors++; $display("FAIL open_done n=%0d got=%0d exp=%0d", q_done.size(), q_done.size() > 0 ? q_done[0] : -1, t0 + 3 + TRP + TRFC - 1); end
        checks++; if (hold_fall != t0 + 3 + TRP + TRFC) begin errors++; $display("FAIL open_hold_fall got=%0d exp=%0d", hold_fall, t0 + 3 + TRP + TRFC); end
    endtask

    task automatic test_back_to_back();
        int t0;
        clr_log(); t0 = cyc;
        for (int k = 0; k < 300; k++) tick(k < 3, 1, 1, 1);
        checks++; if (q_prea_hs.size() != 1 || q_prea_hs[0] != t0 + 3) begin errors++; $display("FAIL b2b_prea n=%0d exp_at=%0d", q_prea_hs.size(), t0 + 3); end
        checks++; if (q_ref_hs.size() != 3) begin errors++; $display("FAIL b2b_ref_count got=%0d exp=3", q_ref_hs.size()); end
        for (int i = 0; i < q_ref_hs.size(); i++) begin
            checks++; if (q_ref_hs[i] != t0 + 3 + TRP + TRFC * i) begin errors++; $display("FAIL b2b_ref_time idx=%0d got=%0d exp=%0d", i, q_ref_hs[i], t0 + 3 + TRP + TRFC * i); end
        end
        checks++; if (n_rise != 1 || n_fall != 1 || hold_fall != t0 + 3 + TRP + 3 * TRFC) begin errors++; $display("FAIL b2b_hold rises=%0d falls=%0d fall_at=%0d exp_fall=%0d", n_rise, n_fall, hold_fall, t0 + 3 + TRP + 3 * TRFC); end
        checks++; if (q_done.size() != 3) begin errors++; $display("FAIL b2b_done_count got=%0d exp=3", q_done.size()); end
    endtask

    task automatic test_stall();
        int t0, stall_bad;
        clr_log(); t0 = cyc; stall_bad = 0;
        for (int k = 0; k < 220; k++) begin
            if (k >= 3 && k < 23 && !(cmd_valid === 1'b1 && cmd_op === 2'b10)) stall_bad++;
            tick(k == 0 || k == 10, 1, 0, !(k >= 3 && k < 23));
        end
        checks++; if (stall_bad != 0) begin errors++; $display("FAIL stall_stable bad_cycles=%0d exp=0", stall_bad); end
        checks++; if (q_ref_hs.size() != 2 || q_ref_hs[0] != t0 + 23 || q_ref_hs[1] != t0 + 23 + TRFC) begin errors++; $display("FAIL stall_ref_hs n=%0d first=%0d exp=%0d,%0d", q_ref_hs.size(), q_ref_hs.size() > 0 ? q_ref_hs[0] : -1, t0 + 23, t0 + 23 + TRFC); end
        checks++; if (q_done.size() != 2 || q_done[0] != t0 + 23 + TRFC - 1) begin errors++; $display("FAIL stall_done n=%0d first=%0d exp=%0d", q_done.size(), q_done.size() > 0 ? q_done[0] : -1, t0 + 23 + TRFC - 1); end
        checks++; if (hold_fall != t0 + 23 + 2 * TRFC) begin errors++; $display("FAIL stall_hold_fall got=%0d exp=%0d", hold_fall, t0 + 23 + 2 * TRFC); end
    endtask

    task automatic test_overflow();
        clr_log();
        repeat (MAXP) tick(1, 0, 0, 1);
        checks++; if (pending !== 4'(MAXP) || overflow !== 1'b0) begin errors++; $display("FAIL ovf_at_max pending=%0d ovf=%b exp=%0d,0", pending, overflow, MAXP); end
        tick(1, 0, 0, 1);
        checks++; if (pending !== 4'(MAXP)) begin errors++; $display("FAIL ovf_saturate got=%0d exp=%0d", pending, MAXP); end
        checks++; if (overflow !== 1'b1 || m_ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", overflow); end
        for (int k = 0; k < 1200 && n_fall == 0; k++) tick(0, 1, 1'($urandom_range(0, 1)), 1);
        checks++; if (n_fall != 1 || q_ref_hs.size() != MAXP) begin errors++; $display("FAIL ovf_drain falls=%0d refs=%0d exp=1,%0d", n_fall, q_ref_hs.size(), MAXP); end
        checks++; if (pending !== 4'd0 || overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky pending=%0d ovf=%b exp=0,1", pending, overflow); end
    endtask

    task automatic test_reset_mid();
        int t0;
        clr_log(); t0 = cyc;
        tick(1, 1, 0, 1);
        repeat (40) tick(0, 1, 0, 1);
        checks++; if (sched_hold !== 1'b1 || q_ref_hs.size() != 1) begin errors++; $display("FAIL mid_in_rfc hold=%b refs=%0d exp=1,1", sched_hold, q_ref_hs.size()); end
        #2 core_arstn = 0;
        #1;
        checks++; if ({sched_hold, cmd_valid, ref_done, overflow} !== 4'b0 || cmd_op !== 2'b00 || pending !== 4'd0) begin errors++; $display("FAIL mid_async_clear hold=%b valid=%b done=%b ovf=%b op=%b pend=%0d exp=all0", sched_hold, cmd_valid, ref_done, overflow, cmd_op, pending); end
        @(posedge core_clk); #1;
        core_arstn = 1;
        m_pend = 0; m_ovf = 0; prev_hold = 0; prev_refv = 0;
        clr_log();
        repeat (150) tick(0, 1, 1, 1);
        checks++; if (n_valid != 0 || q_done.size() != 0 || n_rise != 0) begin errors++; $display("FAIL mid_quiet valid_cycles=%0d dones=%0d rises=%0d exp=0", n_valid, q_done.size(), n_rise); end
        clr_log(); t0 = cyc;
        tick(1, 1, 0, 1);
        repeat (95) tick(0, 1, 0, 1);
        checks++; if (q_refv.size() != 1 || q_refv[0] != t0 + 3) begin errors++; $display("FAIL mid_restart n=%0d got=%0d exp=%0d", q_refv.size(), q_refv.size() > 0 ? q_refv[0] : -1, t0 + 3); end
    endtask

    task automatic test_random();
        int bad_pend, bad_ovf, bad_op, bad_hold;
        bad_pend = 0; bad_ovf = 0; bad_op = 0; bad_hold = 0;
        clr_log();
        for (int k = 0; k < 4000; k++) begin
            if (pending !== 4'(m_pend)) bad_pend++;
            if (overflow !== m_ovf) bad_ovf++;
            if (cmd_valid !== 1'b1 && cmd_op !== 2'b00) bad_op++;
            if (cmd_valid === 1'b1 && sched_hold !== 1'b1) bad_hold++;
            tick($urandom_range(0, 99) < 2, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 9) < 7);
        end
        for (int k = 0; k < 1500 && (sched_hold !== 1'b0 || m_pend != 0); k++) tick(0, 1, 0, 1);
        checks++; if (bad_pend != 0) begin errors++; $display("FAIL rand_pending bad_cycles=%0d exp=0", bad_pend); end
        checks++; if (bad_ovf != 0) begin errors++; $display("FAIL rand_overflow bad_cycles=%0d exp=0", bad_ovf); end
        checks++; if (bad_op != 0) begin errors++; $display("FAIL rand_nop_when_idle bad_cycles=%0d exp=0", bad_op); end
        checks++; if (bad_hold != 0) begin errors++; $display("FAIL rand_hold_with_cmd bad_cycles=%0d exp=0", bad_hold); end
        checks++; if (sched_hold !== 1'b0 || pending !== 4'd0) begin errors++; $display("FAIL rand_drained hold=%b pending=%0d exp=0,0", sched_hold, pending); end
        checks++; if (q_done.size() != q_ref_hs.size() || q_ref_hs.size() == 0) begin errors++; $display("FAIL rand_done_count dones=%0d refs=%0d", q_done.size(), q_ref_hs.size()); end
        for (int i = 0; i < q_done.size() && i < q_ref_hs.size(); i++) begin
            checks++; if (q_done[i] != q_ref_hs[i] + TRFC - 1) begin errors++; $display("FAIL rand_done_time idx=%0d got=%0d exp=%0d", i, q_done[i], q_ref_hs[i] + TRFC - 1); end
        end
        for (int i = 1; i < q_ref_hs.size(); i++) begin
            checks++; if (q_ref_hs[i] - q_ref_hs[i-1] < TRFC) begin errors++; $display("FAIL rand_ref_spacing idx=%0d got=%0d exp>=%0d", i, q_ref_hs[i] - q_ref_hs[i-1], TRFC); end
        end
    endtask

    initial begin
        test_reset();
        test_single_closed();
        test_single_open();
        test_back_to_back();
        test_stall();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/refresh_cmd_sequencer.md
Name: refresh_cmd_sequencer

Overview:
Consumes refresh grants (ref_do) from the refresh timing controller and turns each into a legal DDR command sequence toward the command arbiter.
- Quiesces the scheduler, precharges all banks if any are open, issues REFRESH, then enforces tRFC.
- Queues up to MAX_PEND outstanding grants and drains them back-to-back.
- Sits between the refresh timing controller and the DRAM command bus arbiter.

Parameters:
T_RP, 6, precharge-to-next-command delay in core_clk cycles (>=2)
T_RFC, 88, refresh-to-next-command delay in core_clk cycles (>=2)
MAX_PEND, 8, maximum queued refresh grants (JEDEC postpone limit)
PEND_W, 4, width of pending counter (must hold MAX_PEND)

Ports:
core_clk  in  1  core clock; all logic on rising edge
core_arstn  in  1  asynchronous active-low reset
ref_do  in  1  refresh grant, one request per cycle high
sched_hold  out  1  asks scheduler to stop issuing new row/column commands
sched_idle  in  1  scheduler has no command in flight
any_bank_open  in  1  at least one bank currently active
cmd_valid  out  1  command offered to arbiter
cmd_ready  in  1  arbiter accepts command this cycle
cmd_op  out  2  command: 00 NOP, 01 PREA (A10=1), 10 REF, 11 reserved
ref_done  out  1  one-cycle pulse per completed REF (after tRFC)
pending  out  PEND_W  queued grants not yet issued
overflow  out  1  sticky: grant arrived while pending==MAX_PEND

Behaviour:
- Reset (async, core_arstn low): state IDLE, pending=0, timer=0. All outputs 0: sched_hold=0, cmd_valid=0, cmd_op=NOP, ref_done=0, overflow=0. Reset mid-sequence abandons the sequence with no further command.
- Pending counter: +1 per ref_do cycle, −1 on each REF handshake (cmd_valid&&cmd_ready&&cmd_op==REF). Both in the same cycle leaves it unchanged. At MAX_PEND an incoming ref_do is dropped and overflow is set; overflow clears only on reset.
- States: IDLE, DRAIN, PREA, WAIT_RP, REF, WAIT_RFC.
  - IDLE: if pending>0 go to DRAIN and assert sched_hold next cycle.
  - DRAIN: sched_hold=1. When sched_idle=1, go to PREA if any_bank_open, else to REF.
  - PREA: cmd_valid=1, cmd_op=PREA. Hold both stable until cmd_ready. On handshake go to WAIT_RP.
  - WAIT_RP: if handshake is at cycle n, REF cmd_valid rises at cycle n+T_RP.
  - REF: cmd_valid=1, cmd_op=REF, held until cmd_ready. On handshake go to WAIT_RFC.
  - WAIT_RFC: REF handshake at cycle m. ref_done pulses at cycle m+T_RFC−1. The next state is decided at m+T_RFC:
    - pending>0: go directly to REF (banks remain precharged, sched_hold stays 1).
    - pending==0: go to IDLE and drop sched_hold.
- sched_hold is 1 in every state except IDLE.
- cmd_valid is 1 only in PREA and REF. cmd_op=NOP whenever cmd_valid=0.
- Timer: down-counter of width clog2(max(T_RP,T_RFC)). It loads on handshake and never wraps.
- Arbiter stall (cmd_ready low indefinitely): remain in PREA/REF with outputs stable. Grants keep accumulating.
- sched_idle toggling after DRAIN exit is ignored; the sequencer owns the bus until returning to IDLE.

Decomposition:
- Shared package ddr_pkg holds:
  - cmd_op_t enum (NOP/PREA/REF/RSVD), shared with the command generator.
  - Default timing constants T_RP_CK and T_RFC_CK.
  - ref_seq_state_t enum.
- One natural sub-module, delay_timer: loadable down-counter with a zero flag, reused for tRP and tRFC.

Test Plan:
- Single grant, banks closed, sched_idle=1, cmd_ready=1:
  - ref_do at cycle 0 → sched_hold at 1, REF offered at cycle 3 (no PREA).
  - ref_done at cycle 3+87, sched_hold low at cycle 3+88, pending back to 0.
- Single grant, any_bank_open=1 → PREA handshake at cycle n, REF cmd_valid exactly at n+6, then ref_done as above.
- Three grants back-to-back, cmd_ready=1 → PREA issued once, then three REFs spaced exactly 88 cycles apart. sched_hold stays high throughout and drops after the third tRFC.
- Arbiter stall: cmd_ready=0 for 20 cycles during REF → cmd_valid/cmd_op stay stable, no timer progress. Handshake on cycle 21 then tRFC proceeds normally.
- Overflow: 9 ref_do pulses with sched_idle=0 → pending saturates at 8, overflow=1. Overflow stays 1 after the queue drains.
- Reset asserted mid-WAIT_RFC → all outputs 0 immediately (async). After release, no command is issued until a new ref_do.
